// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the memory-stage LSU and its slave: registered request, single-cycle ack.
interface mem_lsu_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          dreq;
  logic          dwe;
  logic [AW-1:0] daddr;
  logic [3:0]    dbe;
  logic [DW-1:0] dwdata;
  logic          dack;
  logic [DW-1:0] drdata;

  modport master (
    output dreq, dwe, daddr, dbe, dwdata,
    input  dack, drdata
  );

  modport slave (
    input  dreq, dwe, daddr, dbe, dwdata,
    output dack, drdata
  );
endinterface

// File: rtl/mem_lsu.sv
// RV32I memory-stage load/store unit: lane steering, load formatting, one req/ack bus access per op.
// Latency >= 2 stall cycles (request registered, one RESP cycle); stallM holds upstream until dack.
module mem_lsu #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          memreadM,
  input  logic          memwriteM,
  input  logic [2:0]    funct3M,
  input  logic [AW-1:0] aluoutM,
  input  logic [DW-1:0] writedataM,
  output logic [DW-1:0] readdataM,
  output logic          stallM,
  output logic          errM,
  mem_lsu_if.master     dbus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state, state_nxt;
  logic          acc;
  logic          fn_bad;
  logic          misal;
  logic [2:0]    f3_q;
  logic [1:0]    a_q;
  logic [3:0]    be_nxt;
  logic [DW-1:0] wd_nxt;
  logic [DW-1:0] fmt;
  logic [7:0]    bsel;
  logic [15:0]   hsel;

  always_comb begin
    fn_bad = 1'b0;
    misal  = 1'b0;
    if (memwriteM)
      fn_bad = !(funct3M inside {3'b000, 3'b001, 3'b010});
    else if (memreadM)
      fn_bad = funct3M inside {3'b011, 3'b110, 3'b111};
    if (funct3M[1:0] == 2'b01)
      misal = aluoutM[0];
    else if (funct3M[1:0] == 2'b10)
      misal = aluoutM[1:0] != 2'b00;
    errM = (memreadM & memwriteM) | ((memreadM | memwriteM) & (fn_bad | misal));
  end

  assign acc    = (memreadM ^ memwriteM) & !errM;
  assign stallM = acc & (state != RESP);

  always_comb begin
    be_nxt = 4'b1111;
    wd_nxt = writedataM;
    if (memwriteM) begin
      case (funct3M[1:0])
        2'b00: begin
          be_nxt = 4'b0001 << aluoutM[1:0];
          wd_nxt = {(DW/8){writedataM[7:0]}};
        end
        2'b01: begin
          be_nxt = aluoutM[1] ? 4'b1100 : 4'b0011;
          wd_nxt = {(DW/16){writedataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Load formatting uses the width/lane captured at request time, not the live M-stage inputs.
  always_comb begin
    bsel = dbus.drdata[8*a_q +: 8];
    hsel = a_q[1] ? dbus.drdata[31:16] : dbus.drdata[15:0];
    case (f3_q)
      3'b000:  fmt = {{(DW-8){bsel[7]}}, bsel};
      3'b100:  fmt = {{(DW-8){1'b0}}, bsel};
      3'b001:  fmt = {{(DW-16){hsel[15]}}, hsel};
      3'b101:  fmt = {{(DW-16){1'b0}}, hsel};
      default: fmt = dbus.drdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = BUSY;
      BUSY:    if (dbus.dack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbus.dreq   <= 1'b0;
      dbus.dwe    <= 1'b0;
      dbus.daddr  <= '0;
      dbus.dbe    <= 4'b0000;
      dbus.dwdata <= '0;
      readdataM   <= '0;
      f3_q        <= 3'b000;
      a_q         <= 2'b00;
    end else if (state == IDLE && acc) begin
      dbus.dreq   <= 1'b1;
      dbus.dwe    <= memwriteM;
      dbus.daddr  <= {aluoutM[AW-1:2], 2'b00};
      dbus.dbe    <= be_nxt;
      dbus.dwdata <= wd_nxt;
      f3_q        <= funct3M;
      a_q         <= aluoutM[1:0];
    end else if (state == BUSY && dbus.dack) begin
      dbus.dreq <= 1'b0;
      if (!dbus.dwe) readdataM <= fmt;
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized scoreboard bench for mem_lsu against an arithmetic RV32I load/store reference.
module tb_mem_lsu;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memreadM = 1'b0;
  logic        memwriteM = 1'b0;
  logic [2:0]  funct3M = 3'b000;
  logic [31:0] aluoutM = '0;
  logic [31:0] writedataM = '0;
  logic [31:0] readdataM;
  logic        stallM;
  logic        errM;

  mem_lsu_if #(.DW(32), .AW(32)) bus ();

  mem_lsu #(.DW(32), .AW(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .memreadM   (memreadM),
    .memwriteM  (memwriteM),
    .funct3M    (funct3M),
    .aluoutM    (aluoutM),
    .writedataM (writedataM),
    .readdataM  (readdataM),
    .stallM     (stallM),
    .errM       (errM),
    .dbus       (bus)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  bus_t        bus_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] last_rd = '0;
  bit          resp_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int m_size(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_err(input bit r, input bit w, input logic [2:0] f, input logic [31:0] a);
    if (r && w) return 1'b1;
    if (!r && !w) return 1'b0;
    if (w && !(f inside {3'd0, 3'd1, 3'd2})) return 1'b1;
    if (r && !(f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    return (a % m_size(f)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int          sz = m_size(f);
    logic [31:0] mask;
    logic [31:0] v;
    if (sz == 4) return d;
    mask = (32'h1 << (8 * sz)) - 32'h1;
    v = (d >> (8 * (a % 4))) & mask;
    if (f < 3'd4 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bus_t m_bus(input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    bus_t b;
    int   sz = m_size(f);
    b.we   = w;
    b.addr = a - (a % 4);
    b.be   = w ? 4'(((1 << sz) - 1) << (a % 4)) : 4'hF;
    if (sz == 1)      b.wdata = (wd & 32'hFF) * 32'h0101_0101;
    else if (sz == 2) b.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
    else              b.wdata = wd;
    return b;
  endfunction

  // Monitor: compares the presented request every BUSY cycle, retires it on dack, checks readdataM in RESP.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_pend) begin
        resp_pend = 1'b0;
        if (rd_q.size() > 0) chk("readdataM_resp", readdataM, rd_q.pop_front());
        else chk("rd_q_underflow", 32'(rd_q.size()), 32'd1);
      end
      if (rst_n && bus.dreq) begin
        if (bus_q.size() == 0) begin
          chk("dreq_unexpected", 32'(bus.dreq), 32'd0);
        end else begin
          chk("dwe", 32'(bus.dwe), 32'(bus_q[0].we));
          chk("daddr", bus.daddr, bus_q[0].addr);
          chk("dbe", 32'(bus.dbe), 32'(bus_q[0].be));
          if (bus_q[0].we) chk("dwdata", bus.dwdata, bus_q[0].wdata);
          if (bus.dack) begin
            void'(bus_q.pop_front());
            resp_pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic do_op(input bit r, input bit w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdat, input int wt, input bit scramble);
    bit          e;
    int          stall_cnt;
    int          req_cnt;
    logic [31:0] tmp;
    @(posedge clk); #1;
    memreadM = r; memwriteM = w; funct3M = f; aluoutM = a; writedataM = wd;
    bus.dack = 1'b0; bus.drdata = rdat;
    e = m_err(r, w, f, a);
    @(negedge clk);
    chk("errM", 32'(errM), 32'(e));
    if (e || !(r || w)) begin
      chk("stall_noacc", 32'(stallM), 32'd0);
      chk("dreq_noacc", 32'(bus.dreq), 32'd0);
      chk("readdataM_hold", readdataM, last_rd);
    end else begin
      bus_q.push_back(m_bus(w, f, a, wd));
      if (r) last_rd = m_load(f, a, rdat);
      rd_q.push_back(last_rd);
      stall_cnt = int'(stallM);
      req_cnt = int'(bus.dreq);
      for (int i = 0; i <= wt; i++) begin
        @(posedge clk); #1;
        bus.dack = (i == wt);
        if (scramble) begin
          tmp = $urandom;
          aluoutM = {tmp[31:2], a[1:0]};
          bus.drdata = (i == wt) ? rdat : $urandom;
        end
        @(negedge clk);
        stall_cnt += int'(stallM);
        req_cnt += int'(bus.dreq);
      end
      @(posedge clk); #1;
      bus.dack = 1'b0;
      @(negedge clk);
      stall_cnt += int'(stallM);
      req_cnt += int'(bus.dreq);
      chk("stall_cycles", 32'(stall_cnt), 32'(wt + 2));
      chk("dreq_cycles", 32'(req_cnt), 32'(wt + 1));
    end
  endtask

  task automatic reset_mid_busy();
    @(posedge clk); #1;
    memreadM = 1'b1; memwriteM = 1'b0; funct3M = 3'd2; aluoutM = 32'h400; bus.dack = 1'b0;
    bus_q.push_back(m_bus(1'b0, 3'd2, 32'h400, 32'h0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("dreq_busy", 32'(bus.dreq), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("dreq_async_rst", 32'(bus.dreq), 32'd0);
    bus_q.delete();
    rd_q.delete();
    last_rd = '0;
    memreadM = 1'b0;
    bus.dack = 1'b1;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("dreq_after_rst", 32'(bus.dreq), 32'd0);
    chk("readdataM_after_rst", readdataM, 32'h0);
    bus.dack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    int          kind;
    int          sz;
    bus.dack = 1'b0;
    bus.drdata = '0;
    #23;
    chk("rst_readdataM", readdataM, 32'h0);
    chk("rst_dreq", 32'(bus.dreq), 32'd0);
    chk("rst_dwe", 32'(bus.dwe), 32'd0);
    chk("rst_daddr", bus.daddr, 32'h0);
    chk("rst_dbe", 32'(bus.dbe), 32'd0);
    chk("rst_dwdata", bus.dwdata, 32'h0);
    chk("rst_stallM", 32'(stallM), 32'd0);
    rst_n = 1'b1;

    do_op(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    do_op(1, 0, 3'd0, 32'h203, 32'h0, 32'h80FFFFFF, 0, 0);
    do_op(1, 0, 3'd4, 32'h203, 32'h0, 32'h80FFFFFF, 1, 0);
    do_op(1, 0, 3'd5, 32'h202, 32'h0, 32'hBEEF1234, 0, 0);
    do_op(0, 1, 3'd0, 32'h301, 32'h000000A5, 32'h0, 0, 0);
    do_op(0, 1, 3'd1, 32'h302, 32'h00001234, 32'h0, 2, 0);
    do_op(1, 0, 3'd2, 32'h104, 32'h0, 32'hCAFEF00D, 3, 1);
    do_op(1, 0, 3'd2, 32'h102, 32'h0, 32'h11111111, 0, 0);
    do_op(0, 1, 3'd1, 32'h001, 32'h5555, 32'h0, 0, 0);
    do_op(1, 1, 3'd2, 32'h100, 32'h0, 32'h0, 0, 0);
    reset_mid_busy();
    do_op(1, 0, 3'd2, 32'h500, 32'h0, 32'h12345678, 0, 0);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2 || kind > 5) f = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f = 3'd0; 1: f = 3'd1; 2: f = 3'd2; 3: f = 3'd4; default: f = 3'd5;
        endcase
      end
      if ($urandom_range(0, 7) == 0) f = 3'($urandom_range(0, 7));
      a = $urandom;
      sz = m_size(f);
      if ($urandom_range(0, 7) != 0 && sz != 0) a = a - (a % sz);
      do_op(kind == 1 || (kind >= 2 && kind <= 5), kind == 1 || kind >= 6, f, a,
            $urandom, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    memreadM = 1'b0; memwriteM = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
